// File: rtl/opm_window_accum_pkg.sv
// Shared definitions for the per-cycle power model family (opm_*).
// Latency: n/a (types, constants and elaboration-time helper functions only).
// Backpressure: n/a.
package opm_pkg;

    // Defaults of the reference configuration (40 signals, 5-bit weights).
    localparam int DEF_N        = 40;
    localparam int DEF_B        = 5;
    localparam int DEF_OUTSIZE  = 11;
    localparam int DEF_WIN_LOG2 = 4;

    // Address width for an N-entry table. Never returns 0, so a one-entry
    // table still gets a 1-bit address port.
    function automatic int addr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Window sum width: a window holds 2^win_log2 per-cycle sums, so it needs
    // win_log2 extra bits on top of the per-cycle width to be overflow-free.
    function automatic int acc_width(input int outsize, input int win_log2);
        return outsize + win_log2;
    endfunction

    // True when the worst-case per-cycle sum N*(2^B-1) fits in OUTSIZE bits.
    // Also used by the fixed-weight model, so it stays generic.
    function automatic bit outsize_ok(input int n, input int b, input int outsize);
        longint max_sum;
        max_sum = longint'(n) * ((longint'(1) << b) - 1);
        return max_sum < (longint'(1) << outsize);
    endfunction

    // Weight table for the default configuration; benches fill one of these
    // and stream it into the weight write port after reset.
    typedef logic [DEF_B-1:0] weight_tab_t [DEF_N];

endpackage

// File: rtl/opm_window_accum_if.sv
// Bundle of monitored signals, weight write port, threshold and power outputs.
// Latency: n/a (wiring only).
// Backpressure: none; the consumer samples every cycle.
// master: drives sigs/en/w_*/thresh, observes results. slave: the accumulator.
interface opm_window_accum_if #(
    parameter int N        = 40,
    parameter int B        = 5,
    parameter int OUTSIZE  = 11,
    parameter int WIN_LOG2 = 4
);
    localparam int ACCSIZE = opm_pkg::acc_width(OUTSIZE, WIN_LOG2);
    localparam int AW      = opm_pkg::addr_width(N);

    logic               en;
    logic [N-1:0]       sigs;
    logic               w_we;
    logic [AW-1:0]      w_addr;
    logic [B-1:0]       w_data;
    logic [ACCSIZE-1:0] thresh;

    logic [OUTSIZE-1:0] cyc_pwr;
    logic               cyc_vld;
    logic [ACCSIZE-1:0] win_pwr;
    logic               win_vld;
    logic               alarm;

    modport master (
        output en, sigs, w_we, w_addr, w_data, thresh,
        input  cyc_pwr, cyc_vld, win_pwr, win_vld, alarm
    );

    modport slave (
        input  en, sigs, w_we, w_addr, w_data, thresh,
        output cyc_pwr, cyc_vld, win_pwr, win_vld, alarm
    );

endinterface

// File: rtl/opm_window_accum_toggle_sum.sv
// Toggle detector plus weighted sum: two input flops, combinational adder tree.
// Latency: sigs captured at edge k contribute to sum during the cycle after edge k.
// Backpressure: none; a new sample is taken every cycle.
// Ports: clk, rst_n, sigs[N], weight[N][B] (from the owner's register file), sum[OUTSIZE].
module opm_toggle_sum #(
    parameter int N       = 40,
    parameter int B       = 5,
    parameter int OUTSIZE = 11
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [N-1:0]        sigs,
    input  logic [N-1:0][B-1:0] weight,
    output logic [OUTSIZE-1:0]  sum
);

    logic [N-1:0] sigs_r;
    logic [N-1:0] sigs_k;
    logic [N-1:0] tog;

    // sigs_r is the first capture of the asynchronous-domain-free monitored
    // nets; sigs_k is the previous sample it is compared against.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sigs_r <= '0;
            sigs_k <= '0;
        end else begin
            sigs_r <= sigs;
            sigs_k <= sigs_r;
        end
    end

    assign tog = sigs_r ^ sigs_k;

    // Width is guaranteed sufficient by the owner's elaboration check, so the
    // running sum never wraps.
    always_comb begin
        sum = '0;
        for (int i = 0; i < N; i++) begin
            if (tog[i]) begin
                sum = sum + OUTSIZE'(weight[i]);
            end
        end
    end

endmodule

// File: rtl/opm_window_accum.sv
// Programmable-weight per-cycle power estimate with windowed sum and threshold alarm.
// Latency: sigs change at edge k -> cyc_pwr after edge k+1; win_pwr/alarm at the 2^WIN_LOG2-th counted edge.
// Backpressure: none; every cycle is evaluated, en only gates window accumulation.
// Ports: clk, rst_n (async active-low), bus (slave modport: sigs, en, weight write, thresh, power outputs).
module opm_window_accum
    import opm_pkg::*;
#(
    parameter int N        = 40,
    parameter int B        = 5,
    parameter int OUTSIZE  = 11,
    parameter int WIN_LOG2 = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    opm_window_accum_if.slave    bus
);

    localparam int ACCSIZE = acc_width(OUTSIZE, WIN_LOG2);
    localparam int AW      = addr_width(N);

    generate
        if (!outsize_ok(N, B, OUTSIZE)) begin : g_size_check
            $error("opm_window_accum: OUTSIZE too small, N*(2^B-1) must be < 2^OUTSIZE");
        end
    endgenerate

    // ------------------------------------------------------------------
    // Weight register file. Addresses N..2^AW-1 match no entry, so writes
    // to them fall through with no effect.
    // ------------------------------------------------------------------
    logic [N-1:0][B-1:0] weight;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            weight <= '0;
        end else if (bus.w_we) begin
            for (int i = 0; i < N; i++) begin
                if (bus.w_addr == AW'(i)) begin
                    weight[i] <= bus.w_data;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Per-cycle estimate. A write landing on the same edge that registers
    // cyc_pwr is not yet visible to the sum, so it uses the old weight.
    // ------------------------------------------------------------------
    logic [OUTSIZE-1:0] sum;
    logic [OUTSIZE-1:0] cyc_pwr_q;
    logic               cyc_vld_q;
    logic [1:0]         warm_cnt;

    opm_toggle_sum #(
        .N       (N),
        .B       (B),
        .OUTSIZE (OUTSIZE)
    ) u_toggle_sum (
        .clk    (clk),
        .rst_n  (rst_n),
        .sigs   (bus.sigs),
        .weight (weight),
        .sum    (sum)
    );

    // The first two sums after reset compare against reset-state flops rather
    // than real history; warm_cnt hides them and cyc_vld rises on edge 3.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc_pwr_q <= '0;
            cyc_vld_q <= 1'b0;
            warm_cnt  <= 2'd0;
        end else begin
            cyc_pwr_q <= sum;
            if (warm_cnt != 2'd3) begin
                warm_cnt <= warm_cnt + 2'd1;
            end
            cyc_vld_q <= warm_cnt[1];
        end
    end

    // ------------------------------------------------------------------
    // Window accumulation. Cycles with en=0 are skipped entirely, so a
    // window always spans exactly 2^WIN_LOG2 valid, enabled samples.
    // ------------------------------------------------------------------
    logic [ACCSIZE-1:0]  acc;
    logic [ACCSIZE-1:0]  win_sum;
    logic [WIN_LOG2-1:0] win_cnt;
    logic [ACCSIZE-1:0]  win_pwr_q;
    logic                win_vld_q;
    logic                alarm_q;
    logic                counted;

    assign counted = cyc_vld_q & bus.en;
    assign win_sum = acc + ACCSIZE'(cyc_pwr_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc       <= '0;
            win_cnt   <= '0;
            win_pwr_q <= '0;
            win_vld_q <= 1'b0;
            alarm_q   <= 1'b0;
        end else begin
            win_vld_q <= 1'b0;
            if (counted) begin
                if (&win_cnt) begin
                    // Last sample of the window: publish and restart.
                    win_pwr_q <= win_sum;
                    win_vld_q <= 1'b1;
                    alarm_q   <= (win_sum > bus.thresh);
                    acc       <= '0;
                    win_cnt   <= '0;
                end else begin
                    acc     <= win_sum;
                    win_cnt <= win_cnt + 1'b1;
                end
            end
        end
    end

    assign bus.cyc_pwr = cyc_pwr_q;
    assign bus.cyc_vld = cyc_vld_q;
    assign bus.win_pwr = win_pwr_q;
    assign bus.win_vld = win_vld_q;
    assign bus.alarm   = alarm_q;

endmodule

// File: doc/opm_window_accum.md
Name: opm_window_accum

Overview:
- Parametrised successor to the fixed-weight per-cycle power model. Detects per-signal toggles and sums runtime-programmable per-signal weights into a per-cycle power estimate.
- Also accumulates that estimate over a power-of-two window of cycles and raises a threshold alarm per window.
- Sits beside the monitored logic and feeds the power-telemetry path.

Parameters:
- N, 40, number of monitored single-bit signals
- B, 5, weight width in bits
- OUTSIZE, 11, per-cycle sum width; must satisfy N*(2^B-1) < 2^OUTSIZE (elaboration-time check, $error on violation)
- WIN_LOG2, 4, window length = 2^WIN_LOG2 counted cycles
- ACCSIZE, OUTSIZE+WIN_LOG2, window sum width (derived; overflow-free by construction)
- AW, $clog2(N), weight address width (derived)

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  reset, asynchronous assert, active-low
- en  in  1  window accumulation enable
- sigs  in  N  monitored signals
- w_we  in  1  weight write strobe
- w_addr  in  AW  weight index; writes with w_addr >= N are ignored
- w_data  in  B  weight value
- thresh  in  ACCSIZE  alarm threshold, sampled at window close
- cyc_pwr  out  OUTSIZE  registered per-cycle weighted toggle sum
- cyc_vld  out  1  cyc_pwr is meaningful
- win_pwr  out  ACCSIZE  last completed window sum
- win_vld  out  1  one-cycle pulse on window completion
- alarm  out  1  last completed window exceeded thresh

Behaviour:
- Reset values (asynchronous): all weights 0; sigs_r, sigs_k 0; warm-up counter 0; cyc_pwr 0; cyc_vld 0; window accumulator 0; window counter 0; win_pwr 0; win_vld 0; alarm 0.
- Pipeline:
  - sigs_r <= sigs; sigs_k <= sigs_r.
  - tog[i] = sigs_r[i] ^ sigs_k[i].
  - sum = Σ weight[i] for every i with tog[i] = 1, at OUTSIZE width.
  - cyc_pwr <= sum every cycle.
- Latency: an input change captured at edge k appears in cyc_pwr after edge k+1.
- Warm-up: 2-bit saturating counter. cyc_vld goes high on the third edge after reset release and stays high. The toggle sum is computed during warm-up, but cyc_vld = 0 marks it invalid.
- Weight write: when w_we = 1 and w_addr < N, weight[w_addr] <= w_data at the edge. The new weight applies to the sum from the following cycle. A write in the same cycle as a toggle on that index uses the old weight.
- Window accumulation:
  - Counted cycles are cycles with cyc_vld & en.
  - On a counted cycle with counter < 2^WIN_LOG2-1: acc <= acc + cyc_pwr; counter++.
  - On a counted cycle with counter = 2^WIN_LOG2-1:
    - win_pwr <= acc + cyc_pwr
    - win_vld <= 1
    - alarm <= (acc + cyc_pwr) > thresh (unsigned, strict)
    - acc <= 0; counter <= 0 (wrap)
  - win_vld is 0 on every other cycle.
- en = 0: acc and counter freeze; cyc_pwr still updates; the window resumes where it left off when en returns to 1. Those cycles are excluded, not zero-filled.
- alarm is level, not sticky. It is updated only at window close and holds between closes.
- Reset mid-window: partial window discarded, weights lost; software reloads weights.
- No saturation logic is required; widths are sized by the parameter constraints.

Decomposition:
- Shared package opm_pkg holds:
  - clog2-based width helper functions
  - the OUTSIZE-sufficiency check function, reused by the existing fixed-weight model
  - the default weight-table constant type (logic [B-1:0] array), used by benches to preload weights
- One natural sub-module: opm_toggle_sum. It is combinational plus the two input flops, with weights supplied as an input, and produces the sum.
- The top module owns the weight register file, cyc_pwr, warm-up, window and alarm logic.

Test Plan:
- Reset then hold sigs constant for 10 cycles -> cyc_vld rises on the 3rd edge after rst_n high; cyc_pwr = 0; win_vld never pulses before 16 counted cycles.
- Write weight[3] = 5'd18, then toggle sigs[3] at edge k -> cyc_pwr = 18 after edge k+1, 0 after edge k+2.
- All weights 31, toggle all 40 bits every cycle with en = 1 -> cyc_pwr = 1240 steady; win_pwr = 19840 with a win_vld pulse every 16 cycles.
- Same stimulus with en = 0 for 5 cycles mid-window -> win_vld is delayed by exactly 5 cycles; win_pwr is still 19840.
- Windows summing 19840, then 0, with thresh = 19839 -> alarm = 1 after the first close; alarm = 0 after the second close.
- Assert rst_n low after 8 counted cycles -> all outputs 0 immediately (asynchronous). After reload and restart, the first win_vld comes 16 counted cycles later, with no residue from the partial window.
- Write with w_addr = 45 -> no weight changes; cyc_pwr is unaffected.
